// File: rtl/led_ctrl_pkg.sv
// ============================================================================
// Module   : led_ctrl_pkg
// Brief    : Shared types and constants for the rotating LED run controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_ctrl_pkg;

  localparam int N_POS_DEF = 21;
  localparam int POS_W     = 5;
  localparam int PRESC_W   = 25;

  // speed_sel encodings: step period is TICK_BASE divided by 1, 2, 4 or 8
  localparam logic [1:0] SPD_X1 = 2'd0;
  localparam logic [1:0] SPD_X2 = 2'd1;
  localparam logic [1:0] SPD_X4 = 2'd2;
  localparam logic [1:0] SPD_X8 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  function automatic logic [POS_W-1:0] pos_advance(
    input logic [POS_W-1:0] pos,
    input logic             dir,
    input logic [POS_W-1:0] last
  );
    logic [POS_W-1:0] nxt;
    if (!dir) begin
      nxt = (pos == last) ? '0 : pos + POS_W'(1);
    end else begin
      nxt = (pos == '0) ? last : pos - POS_W'(1);
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_run_ctrl_btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-FF synchroniser, level debounce and rising-edge event pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_event
);

  localparam int               CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_event;
  logic [CNT_W-1:0] r_cnt;

  // The counter only advances while the synchronised level disagrees with the
  // accepted one, so any bounce back to the stable level restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_event    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;

      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      r_stable_d <= r_stable;
      r_event    <= r_stable & ~r_stable_d;
    end
  end

  assign o_event = r_event;

endmodule

`default_nettype wire

// File: rtl/led_run_ctrl.sv
// ============================================================================
// Module   : led_run_ctrl
// Brief    : Run/pause/clear sequencer, step prescaler and position register
//            for the 21-position rotating LED display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_run_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_BASE  = 20_000_000,
  parameter int N_POS      = N_POS_DEF,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_btn_start,
  input  logic             i_btn_dir,
  input  logic             i_btn_clr,
  input  logic [1:0]       i_speed_sel,
  output logic [N_POS-1:0] o_led_out,
  output logic [POS_W-1:0] o_pos,
  output logic             o_dir,
  output logic             o_step,
  output logic             o_running
);

  localparam logic [PRESC_W-1:0] C_TICK   = PRESC_W'(TICK_BASE);
  localparam logic [POS_W-1:0]   C_LAST   = POS_W'(N_POS - 1);
  localparam logic [N_POS-1:0]   C_LED0   = N_POS'(1);

  logic               w_start_ev;
  logic               w_dir_ev;
  logic               w_clr_ev;
  logic [PRESC_W-1:0] w_period;
  logic [PRESC_W-1:0] w_limit;
  logic               w_step_due;
  logic [POS_W-1:0]   w_pos_next;

  state_t             r_state;
  logic [PRESC_W-1:0] r_presc;
  logic [POS_W-1:0]   r_pos;
  logic [N_POS-1:0]   r_led;
  logic               r_dir;
  logic               r_step;
  logic               r_running;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (i_btn_start),
    .o_event (w_start_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (i_btn_dir),
    .o_event (w_dir_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (i_btn_clr),
    .o_event (w_clr_ev)
  );

  always_comb begin
    w_period = C_TICK;
    case (i_speed_sel)
      SPD_X1:  w_period = C_TICK;
      SPD_X2:  w_period = C_TICK >> 1;
      SPD_X4:  w_period = C_TICK >> 2;
      SPD_X8:  w_period = C_TICK >> 3;
      default: w_period = C_TICK;
    endcase
  end

  // >= rather than == so a shortened period fires at once instead of wrapping
  assign w_limit    = w_period - PRESC_W'(1);
  assign w_step_due = (r_state == RUN) && (r_presc >= w_limit);
  assign w_pos_next = pos_advance(r_pos, r_dir, C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_pos     <= '0;
      r_led     <= C_LED0;
      r_dir     <= 1'b0;
      r_step    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_step <= 1'b0;

      // A same-cycle step reads r_dir before this toggle lands.
      if (w_dir_ev) begin
        r_dir <= ~r_dir;
      end

      if (w_clr_ev) begin
        r_state   <= IDLE;
        r_presc   <= '0;
        r_pos     <= '0;
        r_led     <= C_LED0;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start_ev) begin
              r_state   <= RUN;
              r_presc   <= '0;
              r_running <= 1'b1;
            end
          end
          RUN: begin
            if (w_start_ev) begin
              r_state   <= PAUSE;
              r_running <= 1'b0;
            end else if (w_step_due) begin
              r_presc <= '0;
              r_step  <= 1'b1;
              r_pos   <= w_pos_next;
              r_led   <= C_LED0 << w_pos_next;
            end else begin
              r_presc <= r_presc + PRESC_W'(1);
            end
          end
          PAUSE: begin
            if (w_start_ev) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_led_out = r_led;
  assign o_pos     = r_pos;
  assign o_dir     = r_dir;
  assign o_step    = r_step;
  assign o_running = r_running;

endmodule

`default_nettype wire

// File: tb/tb_led_run_ctrl.sv
// ============================================================================
// Module   : tb_led_run_ctrl
// Brief    : Scoreboard bench for led_run_ctrl with TICK_BASE=16, DEB_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_led_run_ctrl;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_dir   = 1'b0;
  logic        btn_clr   = 1'b0;
  logic [1:0]  speed_sel = 2'd0;
  logic [20:0] led_out;
  logic [4:0]  pos;
  logic        dir;
  logic        step;
  logic        running;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  int m_pos   = 0;
  bit m_dir   = 1'b0;

  always #5 clk = ~clk;

  led_run_ctrl #(
    .TICK_BASE  (16),
    .N_POS      (21),
    .DEB_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_btn_start (btn_start),
    .i_btn_dir   (btn_dir),
    .i_btn_clr   (btn_clr),
    .i_speed_sel (speed_sel),
    .o_led_out   (led_out),
    .o_pos       (pos),
    .o_dir       (dir),
    .o_step      (step),
    .o_running   (running)
  );

  function automatic int nxt(input int p, input bit d);
    if (!d) return (p == 20) ? 0 : p + 1;
    return (p == 0) ? 20 : p - 1;
  endfunction

  // Every step strobe must match the oldest predicted position.
  always @(negedge clk) begin
    if (rst_n && step) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_step: got pos=%0d with no step expected", pos);
      end else begin
        automatic int e = exp_q.pop_front();
        automatic logic [20:0] e_led = 21'd1 << e;
        if (pos !== 5'(e) || led_out !== e_led)
          $display("FAIL step_pos: got pos=%0d led=%h expected pos=%0d led=%h", pos, led_out, e, e_led);
        else
          n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_step(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!step && cyc < max);
    if (!step) cyc = -1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    tick(3);
    n_total++;
    if (pos !== 5'd0) $display("FAIL reset_pos: got %0d expected 0", pos); else n_pass++;
    n_total++;
    if (led_out !== 21'd1) $display("FAIL reset_led: got %h expected 000001", led_out); else n_pass++;
    n_total++;
    if ({dir, step, running} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {dir, step, running});
    else n_pass++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_start;
    int cyc;
    btn_start = 1'b1;
    tick(7);
    n_total++;
    if (running !== 1'b0) $display("FAIL start_early: got running=%b expected 0", running); else n_pass++;
    tick(1);
    n_total++;
    if (running !== 1'b1) $display("FAIL start_latency: got running=%b expected 1", running); else n_pass++;
    tick(2);
    btn_start = 1'b0;
    m_pos = nxt(m_pos, m_dir);
    exp_q.push_back(m_pos);
    wait_step(40, cyc);
    n_total++;
    if (cyc !== 14) $display("FAIL first_step_delay: got %0d expected 14", cyc); else n_pass++;
    n_total++;
    if (led_out !== 21'h000002) $display("FAIL first_step_led: got %h expected 000002", led_out); else n_pass++;
  endtask

  task automatic test_wrap;
    int cyc;
    do begin
      m_pos = nxt(m_pos, m_dir);
      exp_q.push_back(m_pos);
      wait_step(40, cyc);
      n_total++;
      if (cyc !== 16) $display("FAIL step_period: got %0d expected 16", cyc); else n_pass++;
      if (m_pos == 20) begin
        n_total++;
        if (led_out !== 21'h100000) $display("FAIL led_top: got %h expected 100000", led_out); else n_pass++;
      end
    end while (m_pos != 0);
    n_total++;
    if (pos !== 5'd0 || led_out !== 21'd1)
      $display("FAIL wrap_up: got pos=%0d led=%h expected pos=0 led=000001", pos, led_out);
    else n_pass++;
    tick(1);
    btn_dir = 1'b1;
    tick(8);
    n_total++;
    if (dir !== 1'b1) $display("FAIL dir_toggle: got %b expected 1", dir); else n_pass++;
    btn_dir = 1'b0;
    m_dir = 1'b1;
    m_pos = nxt(m_pos, m_dir);
    exp_q.push_back(m_pos);
    wait_step(40, cyc);
    n_total++;
    if (cyc !== 7 || pos !== 5'd20) $display("FAIL wrap_down: got cyc=%0d pos=%0d expected cyc=7 pos=20", cyc, pos);
    else n_pass++;
  endtask

  task automatic test_pause_resume;
    int cyc;
    tick(2);
    btn_start = 1'b1;
    tick(8);
    n_total++;
    if (running !== 1'b0) $display("FAIL pause_enter: got running=%b expected 0", running); else n_pass++;
    btn_start = 1'b0;
    tick(20);
    n_total++;
    if (dut.r_presc !== 25'd9) $display("FAIL presc_frozen: got %0d expected 9", dut.r_presc); else n_pass++;
    btn_start = 1'b1;
    tick(8);
    n_total++;
    if (running !== 1'b1) $display("FAIL resume: got running=%b expected 1", running); else n_pass++;
    btn_start = 1'b0;
    m_pos = nxt(m_pos, m_dir);
    exp_q.push_back(m_pos);
    wait_step(40, cyc);
    n_total++;
    if (cyc !== 7) $display("FAIL resume_step: got %0d expected 7", cyc); else n_pass++;
  endtask

  task automatic test_speed;
    int cyc;
    tick(10);
    speed_sel = 2'd2;
    m_pos = nxt(m_pos, m_dir);
    exp_q.push_back(m_pos);
    wait_step(4, cyc);
    n_total++;
    if (cyc !== 1) $display("FAIL speed_immediate: got %0d expected 1", cyc); else n_pass++;
    n_total++;
    if (dut.r_presc !== 25'd0) $display("FAIL speed_presc: got %0d expected 0", dut.r_presc); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      m_pos = nxt(m_pos, m_dir);
      exp_q.push_back(m_pos);
      wait_step(10, cyc);
      n_total++;
      if (cyc !== 4) $display("FAIL speed_period: got %0d expected 4", cyc); else n_pass++;
    end
  endtask

  task automatic test_priority;
    m_pos = nxt(m_pos, m_dir);
    exp_q.push_back(m_pos);
    btn_clr   = 1'b1;
    btn_start = 1'b1;
    tick(8);
    m_pos = 0;
    n_total++;
    if (running !== 1'b0 || pos !== 5'd0 || led_out !== 21'd1)
      $display("FAIL clr_priority: got running=%b pos=%0d led=%h expected 0/0/000001", running, pos, led_out);
    else n_pass++;
    n_total++;
    if (dir !== m_dir) $display("FAIL clr_keeps_dir: got %b expected %b", dir, m_dir); else n_pass++;
    btn_clr   = 1'b0;
    btn_start = 1'b0;
    tick(20);
    n_total++;
    if (running !== 1'b0 || pos !== 5'd0) $display("FAIL idle_hold: got running=%b pos=%0d expected 0/0", running, pos);
    else n_pass++;
    btn_start = 1'b1;
    tick(3);
    btn_start = 1'b0;
    tick(15);
    n_total++;
    if (running !== 1'b0) $display("FAIL glitch_filter: got running=%b expected 0", running); else n_pass++;
  endtask

  task automatic test_async_reset;
    int cyc;
    btn_start = 1'b1;
    tick(8);
    n_total++;
    if (running !== 1'b1) $display("FAIL restart: got running=%b expected 1", running); else n_pass++;
    btn_start = 1'b0;
    while (m_pos != 7) begin
      m_pos = nxt(m_pos, m_dir);
      exp_q.push_back(m_pos);
      wait_step(10, cyc);
      if (cyc < 0) begin
        n_total++;
        $display("FAIL step_timeout: got none expected pos=%0d", m_pos);
        break;
      end
    end
    n_total++;
    if (pos !== 5'd7) $display("FAIL pre_reset_pos: got %0d expected 7", pos); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({pos, led_out, dir, step, running} !== {5'd0, 21'd1, 3'b000})
      $display("FAIL async_reset: got pos=%0d led=%h flags=%b expected 0/000001/000", pos, led_out, {dir, step, running});
    else n_pass++;
    btn_start = 1'b1;
    tick(2);
    rst_n = 1'b1;
    m_dir = 1'b0;
    m_pos = 0;
    tick(7);
    n_total++;
    if (running !== 1'b0) $display("FAIL held_early: got running=%b expected 0", running); else n_pass++;
    tick(1);
    n_total++;
    if (running !== 1'b1) $display("FAIL held_accept: got running=%b expected 1", running); else n_pass++;
    btn_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_wrap();
    test_pause_resume();
    test_speed();
    test_priority();
    test_async_reset();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL steps_missing: got %0d pending expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
